// File: rtl/pe_dot_engine.sv
// Signed dot-product engine: streams operand/weight pairs through a two-stage
// saturating MAC, then requantises, activates and saturates one result per start.
module pe_dot_engine #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 16,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [5:0]        cfg_shift,
    input  logic [1:0]        cfg_act,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] wt_data,
    input  logic              wt_valid,
    output logic              wt_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_sat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    // state  | meaning
    // IDLE   | waiting for start
    // ACCUM  | accepting pairs until the remaining-term counter reaches zero
    // DRAIN  | letting the registered product land in the accumulator
    // POST   | round, shift, activate, saturate; register the result
    // OUT    | result presented until consumer handshake
    typedef enum logic [2:0] {
        S_IDLE, S_ACCUM, S_DRAIN, S_POST, S_OUT
    } state_t;

    localparam int PROD_W = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] CLIP_HI = {{(ACC_W-OUT_W+1){1'b0}}, 1'b1, {(OUT_W-2){1'b0}}};

    state_t                   state_q, state_d;
    logic [LEN_W-1:0]         remain_q, remain_d;
    logic [5:0]               shift_q, shift_d;
    logic [1:0]               act_q, act_d;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic                     prod_vld_q, prod_vld_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     acc_sat_q, acc_sat_d;
    logic [OUT_W-1:0]         out_data_q, out_data_d;
    logic [ACC_W-1:0]         out_acc_q, out_acc_d;
    logic                     out_sat_q, out_sat_d;

    logic                     pair_fire;
    logic signed [PROD_W-1:0] in_ext, wt_ext;
    logic signed [ACC_W:0]    acc_sum, rnd_inc, rnd_sum;
    logic signed [ACC_W-1:0]  rnd_val, shr_val, act_val;
    logic                     rnd_sat, clip_sat;
    logic [OUT_W-1:0]         post_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            remain_q   <= '0;
            shift_q    <= '0;
            act_q      <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            acc_sat_q  <= 1'b0;
            out_data_q <= '0;
            out_acc_q  <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            remain_q   <= remain_d;
            shift_q    <= shift_d;
            act_q      <= act_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
            acc_sat_q  <= acc_sat_d;
            out_data_q <= out_data_d;
            out_acc_q  <= out_acc_d;
            out_sat_q  <= out_sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (cfg_len == '0) ? S_DRAIN : S_ACCUM;
            S_ACCUM: if (pair_fire && remain_q == LEN_W'(1)) state_d = S_DRAIN;
            S_DRAIN: if (!prod_vld_q) state_d = S_POST;
            S_POST:  state_d = S_OUT;
            S_OUT:   if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_ACCUM) && (remain_q != '0);
        wt_ready  = in_ready;
        out_valid = (state_q == S_OUT);
        busy      = (state_q != S_IDLE);
    end

    assign pair_fire = in_ready && in_valid && wt_valid;
    assign out_data  = out_data_q;
    assign out_acc   = out_acc_q;
    assign out_sat   = out_sat_q;

    // MAC datapath and cfg latching
    always_comb begin
        remain_d   = remain_q;
        shift_d    = shift_q;
        act_d      = act_q;
        acc_d      = acc_q;
        acc_sat_d  = acc_sat_q;
        in_ext     = {{DATA_W{in_data[DATA_W-1]}}, in_data};
        wt_ext     = {{DATA_W{wt_data[DATA_W-1]}}, wt_data};
        prod_d     = pair_fire ? in_ext * wt_ext : prod_q;
        prod_vld_d = pair_fire;
        acc_sum    = {acc_q[ACC_W-1], acc_q}
                   + {{(ACC_W+1-PROD_W){prod_q[PROD_W-1]}}, prod_q};

        if (prod_vld_q) begin
            if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
                acc_d     = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
                acc_sat_d = 1'b1;
            end else begin
                acc_d = acc_sum[ACC_W-1:0];
            end
        end
        if (pair_fire) remain_d = remain_q - LEN_W'(1);
        if (state_q == S_IDLE && start) begin
            remain_d  = cfg_len;
            shift_d   = cfg_shift;
            act_d     = cfg_act;
            acc_d     = '0;
            acc_sat_d = 1'b0;
        end
    end

    // Requantise and activate; only captured into the output flops in POST
    always_comb begin
        rnd_inc = '0;
        if (shift_q != 6'd0) rnd_inc = {{ACC_W{1'b0}}, 1'b1} << (shift_q - 6'd1);
        rnd_sum = {acc_q[ACC_W-1], acc_q} + rnd_inc;
        rnd_sat = 1'b0;
        rnd_val = rnd_sum[ACC_W-1:0];
        if (rnd_sum[ACC_W] != rnd_sum[ACC_W-1]) begin
            rnd_val = rnd_sum[ACC_W] ? ACC_MIN : ACC_MAX;
            rnd_sat = 1'b1;
        end
        shr_val = rnd_val >>> shift_q;

        act_val = shr_val;
        case (act_q)
            2'd1: if (shr_val[ACC_W-1]) act_val = '0;
            2'd2: if (shr_val[ACC_W-1]) act_val = shr_val >>> 3;
            2'd3: begin
                if (shr_val[ACC_W-1])        act_val = '0;
                else if (shr_val > CLIP_HI)  act_val = CLIP_HI;
            end
            default: act_val = shr_val;
        endcase

        clip_sat  = 1'b0;
        post_data = act_val[OUT_W-1:0];
        if (act_val > OUT_MAX) begin
            post_data = OUT_MAX[OUT_W-1:0];
            clip_sat  = 1'b1;
        end else if (act_val < OUT_MIN) begin
            post_data = OUT_MIN[OUT_W-1:0];
            clip_sat  = 1'b1;
        end

        out_data_d = out_data_q;
        out_acc_d  = out_acc_q;
        out_sat_d  = out_sat_q;
        if (state_q == S_POST) begin
            out_data_d = post_data;
            out_acc_d  = acc_q;
            out_sat_d  = acc_sat_q | rnd_sat | clip_sat;
        end
    end

endmodule

// File: tb/tb_pe_dot_engine.sv
// Directed bench for pe_dot_engine: hand-computed dot products, rounding,
// activation, saturation, latency, backpressure and mid-operation reset.
module tb_pe_dot_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  cfg_len;
    logic [5:0]  cfg_shift;
    logic [1:0]  cfg_act;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] wt_data;
    logic        wt_valid;
    logic        wt_ready;
    logic [15:0] out_data;
    logic [39:0] out_acc;
    logic        out_sat;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [15:0] vin [1024];
    logic [15:0] vwt [1024];

    pe_dot_engine #(.DATA_W(16), .ACC_W(40), .OUT_W(16), .LEN_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
        .cfg_shift(cfg_shift), .cfg_act(cfg_act),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wt_data(wt_data), .wt_valid(wt_valid), .wt_ready(wt_ready),
        .out_data(out_data), .out_acc(out_acc), .out_sat(out_sat),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input int len, input int shift, input int act,
                          input bit skew, input int hold, input logic [15:0] e_data,
                          input logic [39:0] e_acc, input logic e_sat);
        int  i;
        int  n;
        int  guard;
        bit  fire;
        i = 0;
        guard = 0;
        @(negedge clk);
        start = 1'b1; cfg_len = 10'(len); cfg_shift = 6'(shift); cfg_act = 2'(act);
        @(negedge clk);
        start = 1'b0; cfg_len = 10'h3FF; cfg_shift = 6'd9; cfg_act = 2'(act ^ 1);
        if (len == 0) begin
            n = 1;
        end else begin
            while (i < len && guard < 4000) begin
                in_data = vin[i];
                wt_data = vwt[i];
                if (skew) begin
                    in_valid = 1'($urandom_range(0, 1));
                    wt_valid = 1'($urandom_range(0, 1));
                end else begin
                    in_valid = 1'b1;
                    wt_valid = 1'b1;
                end
                #1;
                fire = in_ready && in_valid && wt_valid;
                @(posedge clk);
                if (fire) i++;
                guard++;
                if (i < len) @(negedge clk);
            end
            chk({tag, " pairs"}, 64'(i), 64'(len));
            @(negedge clk);
            n = 1;
        end
        in_valid = 1'b0;
        wt_valid = 1'b0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 64'(n), (len == 0) ? 64'd3 : 64'd4);
        chk({tag, " out_data"}, 64'(out_data), 64'(e_data));
        chk({tag, " out_acc"}, 64'(out_acc), 64'(e_acc));
        chk({tag, " out_sat"}, 64'(out_sat), 64'(e_sat));
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                start = 1'b1; cfg_len = 10'd5; cfg_shift = 6'd3; cfg_act = 2'd2;
            end
            start = 1'b0;
            chk({tag, " held valid"}, 64'(out_valid), 64'd1);
            chk({tag, " held data"}, 64'(out_data), 64'(e_data));
            chk({tag, " held acc"}, 64'(out_acc), 64'(e_acc));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " valid drop"}, 64'(out_valid), 64'd0);
        chk({tag, " idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_len = '0; cfg_shift = '0; cfg_act = '0;
        in_data = '0; in_valid = 1'b0; wt_data = '0; wt_valid = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst in_ready", 64'(in_ready), 64'd0);
        chk("rst wt_ready", 64'(wt_ready), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst out_sat", 64'(out_sat), 64'd0);
        chk("rst out_data", 64'(out_data), 64'd0);
        chk("rst out_acc", 64'(out_acc), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vin[0] = 16'd1; vin[1] = 16'd2; vin[2] = 16'd3; vin[3] = 16'd4;
        vwt[0] = 16'd5; vwt[1] = 16'd6; vwt[2] = 16'd7; vwt[3] = 16'd8;
        run_op("basic", 4, 0, 0, 1'b0, 0, 16'd70, 40'd70, 1'b0);

        for (int k = 0; k < 3; k++) begin vin[k] = 16'(-100); vwt[k] = 16'd10; end
        run_op("relu", 3, 0, 1, 1'b0, 0, 16'd0, 40'(-3000), 1'b0);
        run_op("leaky", 3, 0, 2, 1'b0, 0, 16'(-375), 40'(-3000), 1'b0);
        run_op("none neg", 3, 0, 0, 1'b0, 0, 16'(-3000), 40'(-3000), 1'b0);

        vin[0] = 16'h7FFF; vin[1] = 16'h7FFF; vwt[0] = 16'h7FFF; vwt[1] = 16'h7FFF;
        run_op("out sat", 2, 0, 0, 1'b0, 0, 16'h7FFF, 40'h007FFE0002, 1'b1);

        vin[0] = 16'd7; vwt[0] = 16'd1;
        run_op("round s1", 1, 1, 0, 1'b0, 0, 16'd4, 40'd7, 1'b0);
        run_op("round s2", 1, 2, 0, 1'b0, 0, 16'd2, 40'd7, 1'b0);
        vin[0] = 16'(-7);
        run_op("round neg", 1, 1, 0, 1'b0, 0, 16'(-3), 40'(-7), 1'b0);

        run_op("len zero", 0, 0, 0, 1'b0, 0, 16'd0, 40'd0, 1'b0);

        vin[0] = 16'd20000; vwt[0] = 16'd1;
        run_op("clip hi", 1, 0, 3, 1'b0, 0, 16'd16384, 40'd20000, 1'b0);
        vin[0] = 16'(-20000);
        run_op("clip lo", 1, 0, 3, 1'b0, 0, 16'd0, 40'(-20000), 1'b0);

        vin[0] = 16'd3; vin[1] = 16'(-4); vin[2] = 16'd5; vin[3] = 16'(-6); vin[4] = 16'd7;
        vwt[0] = 16'd2; vwt[1] = 16'd2;   vwt[2] = 16'(-3); vwt[3] = 16'(-3); vwt[4] = 16'd1;
        run_op("skew hold", 5, 0, 0, 1'b1, 5, 16'd8, 40'd8, 1'b0);

        for (int k = 0; k < 513; k++) begin vin[k] = 16'h8000; vwt[k] = 16'h8000; end
        run_op("acc sat", 513, 0, 0, 1'b0, 0, 16'h7FFF, 40'h7FFFFFFFFF, 1'b1);

        // abort in the middle of accumulation
        vin[0] = 16'd1; vin[1] = 16'd2; vin[2] = 16'd3; vin[3] = 16'd4;
        vwt[0] = 16'd5; vwt[1] = 16'd6; vwt[2] = 16'd7; vwt[3] = 16'd8;
        @(negedge clk);
        start = 1'b1; cfg_len = 10'd4; cfg_shift = 6'd0; cfg_act = 2'd0;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; wt_valid = 1'b1; in_data = vin[0]; wt_data = vwt[0];
        @(negedge clk);
        in_data = vin[1]; wt_data = vwt[1];
        @(negedge clk);
        chk("mid in_ready", 64'(in_ready), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        in_valid = 1'b0; wt_valid = 1'b0;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort in_ready", 64'(in_ready), 64'd0);
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort out_acc", 64'(out_acc), 64'd0);
        chk("abort out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after abort", 4, 0, 0, 1'b0, 0, 16'd70, 40'd70, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
